mem_port_sequencer: RTL and testbench
=====================================

# mem_port_sequencer

Owns the single memory port and sequences a test/boot run. While the core is idle it gives the port to a host loader, which writes, reads back and dumps memory. On `start` it resets and triggers the core and hands the port to the fetcher for a bounded number of cycles. It then reclaims the port and freezes the core so that register and memory state stays inspectable. It sits between `mem`, `fetcher`/`decoder` and the host/bench, and replaces ad-hoc port muxing and manual cycle loops.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: memory address width.
- `DATA_WIDTH`, default `` `REG_WIDTH ``: memory data width.
- `CYCLE_WIDTH`, default 16: width of the run-length counter.

- `clk`: in, 1. Single clock (phi2 domain); all state updates on rising edge.
- `reset_n`: in, 1. Asynchronous, active-low reset.
- `host_req`: in, 1. Host requests a port access.
- `host_we`: in, 1. Access is a write (1) or a read (0).
- `host_addr`: in, ADDR_WIDTH. Host address.
- `host_din`: in, DATA_WIDTH. Host write data.
- `host_gnt`: out, 1. Host access is performed this cycle.
- `host_rvalid`: out, 1. `host_rdata` is valid.
- `host_rdata`: out, DATA_WIDTH. Read data returned to the host.
- `start`: in, 1. Begin a run; sampled in LOAD only.
- `stop`: in, 1. Abort a run early.
- `run_cycles`: in, CYCLE_WIDTH. Run length in cycles; 0 means unlimited (the run ends only on `stop`).
- `core_addr`: in, ADDR_WIDTH. Fetcher address.
- `core_din`: in, DATA_WIDTH. Core write data.
- `core_we`: in, 1. Core write enable.
- `mem_addr`: out, ADDR_WIDTH. Address to `mem`.
- `mem_din`: out, DATA_WIDTH. Write data to `mem`.
- `mem_we`: out, 1. Write enable to `mem`.
- `mem_dout`: in, DATA_WIDTH. Registered read data from `mem`.
- `core_reset_n`: out, 1. Reset to the core.
- `core_en`: out, 1. Core is allowed to run.
- `trigger`: out, 1. One-cycle `get_next` pulse to the fetcher.
- `busy`: out, 1. A run is in progress.
- `done`: out, 1. One-cycle pulse when a run ends.

## Operation
- FSM states: LOAD, ARM_RST, ARM_GO, RUN, DRAIN.
- **LOAD**
  - Host owns the port: `mem_* = host_*` gated by `host_req`, and `host_gnt = host_req`.
  - If `start` is high: go to ARM_RST.
  - If `start` and `host_req` are high in the same cycle, the host access completes this cycle and the FSM leaves next cycle.
- **ARM_RST**
  - `core_reset_n = 0`, `core_en = 0`, `mem_we = 0`.
  - Go to ARM_GO.
- **ARM_GO**
  - `core_reset_n = 1`, `trigger = 1`, `core_en = 1`, port owned by the core.
  - Counter loads `run_cycles`.
  - Go to RUN.
- **RUN**
  - Core owns the port: `mem_addr = core_addr`, `mem_din = core_din`, `mem_we = core_we`.
  - Counter decrements by 1 per cycle.
  - Exit to DRAIN when the counter reaches 1, or when `stop` is high. `stop` wins over the count.
  - With `run_cycles == 0` the counter is disabled and only `stop` exits.
- **DRAIN**
  - `core_en = 0`, `mem_we = 0`, `done = 1`.
  - Go to LOAD.
- Host behaviour outside LOAD:
  - `host_gnt = 0`; the host must hold `host_req` until granted.
  - Requests are never dropped or queued.
- Read return: a granted read (`host_we = 0`) sets `host_rvalid` for the next cycle, with `host_rdata = mem_dout`.
- Core state after a run:
  - `core_reset_n` stays 1 after a run, so core state persists until the next `start`.
  - `core_reset_n` is 0 from reset until the first ARM_GO.
- Outputs and state in the FSM: `busy = 1` in ARM_RST, ARM_GO and RUN.

## Timing
- Reset values: state LOAD, counter 0, `core_reset_n = 0`, `core_en = 0`, `trigger = 0`, `done = 0`, `busy = 0`, `host_rvalid = 0`, `host_gnt = 0`.
- Output timing: `mem_*` and `host_gnt` are combinational from the registered state and the current inputs; all other outputs are registered state decodes.
- Latency:
  - `start` sampled in cycle n → ARM_RST in n+1 → `trigger` in n+2 → RUN from n+3.
  - RUN lasts exactly `run_cycles - 1` cycles, plus the ARM_GO cycle, giving `run_cycles` core cycles with port ownership.
  - DRAIN follows; the host can be granted again 1 cycle after `done`.
- Counter: unsigned, CYCLE_WIDTH bits, never wraps. `run_cycles = 1` goes ARM_GO → DRAIN directly.
- Reset mid-run: immediate return to LOAD. The core is held in reset and any outstanding `host_rvalid` is cleared.
- `start` outside LOAD is ignored. `stop` outside RUN is ignored.

## Structure
- `PKG/pkg.v` gets the state encodings `` `SEQ_LOAD `` … `` `SEQ_DRAIN `` (3 bits) and `` `SEQ_CYCLE_WIDTH ``.
- One sub-module: `run_counter`, a loadable down-counter with an enable and a `count_is_one` flag.
- The top level contains the FSM, the port mux and the read-valid flop.

## Test plan
- **Host load and readback:** write 0xA5 to 0x0010 in LOAD, then read it → `host_gnt` high both cycles; next cycle `host_rvalid = 1`, `host_rdata = 0xA5`.
- **Bounded run:** `run_cycles = 20`, `start` → `core_reset_n` low for 1 cycle, `trigger` pulses once 2 cycles after `start`, `mem_addr` follows `core_addr` for 20 cycles, `done` pulses, then the FSM is in LOAD.
- **Stop and unlimited:** `run_cycles = 0`, `stop` after 37 RUN cycles → DRAIN next cycle, `done` once, and no `core_we` reaches `mem_we` after `stop`.
- **Host blocked during run:** `host_req` with a write of 0x3C to 0x0001 is held through RUN → never granted and memory is unchanged; it is granted in the first LOAD cycle after `done` and the write lands there.
- **Simultaneous `start` and `host_req`:** write 0x77 in the same LOAD cycle as `start` → the write lands, and the next state is ARM_RST.
- **Reset mid-run:** assert `reset_n = 0` at RUN cycle 5 → asynchronously `busy = 0`, `core_reset_n = 0`, state LOAD; a later `start` runs the full `run_cycles`.

Source files
------------

// File: rtl/mem_port_sequencer_pkg.sv
// Shared definitions for the memory port sequencer: default widths, FSM
// state encoding and the bundle of registered control outputs together with
// the decode that maps a state onto those outputs.
package mem_port_sequencer_pkg;

    localparam int unsigned SEQ_ADDR_WIDTH  = 16;
    localparam int unsigned SEQ_DATA_WIDTH  = 8;
    localparam int unsigned SEQ_CYCLE_WIDTH = 16;
    localparam int unsigned SEQ_STATE_WIDTH = 3;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_LOAD    = 3'd0,
        SEQ_ARM_RST = 3'd1,
        SEQ_ARM_GO  = 3'd2,
        SEQ_RUN     = 3'd3,
        SEQ_DRAIN   = 3'd4
    } seq_state_e;

    // Registered control outputs driven towards the core and the host.
    typedef struct packed {
        logic core_reset_n;
        logic core_en;
        logic trigger;
        logic busy;
        logic done;
    } seq_ctl_t;

    localparam seq_ctl_t SEQ_CTL_RESET = '0;

    // Control outputs for a given state. core_reset_n is sticky: only the
    // arm sequence changes it, so core state survives past the end of a run.
    function automatic seq_ctl_t seq_ctl_decode(input seq_state_e state,
                                                input logic       core_reset_n_prev);
        seq_ctl_t ctl;
        ctl              = SEQ_CTL_RESET;
        ctl.core_reset_n = core_reset_n_prev;
        case (state)
            SEQ_ARM_RST: begin
                ctl.core_reset_n = 1'b0;
                ctl.busy         = 1'b1;
            end
            SEQ_ARM_GO: begin
                ctl.core_reset_n = 1'b1;
                ctl.core_en      = 1'b1;
                ctl.trigger      = 1'b1;
                ctl.busy         = 1'b1;
            end
            SEQ_RUN: begin
                ctl.core_en = 1'b1;
                ctl.busy    = 1'b1;
            end
            SEQ_DRAIN: begin
                ctl.done = 1'b1;
            end
            default: begin
            end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/mem_port_sequencer_run_counter.sv
// Loadable run-length down-counter.
//   clk, reset_n  : clock, asynchronous active-low reset
//   load          : load load_val (has priority over en)
//   load_val      : run length; 0 disables counting entirely
//   en            : decrement by one this cycle
//   count_is_one  : registered flag, high while the count equals 1
// The count saturates at 0, so a zero load stays at zero (unlimited run) and
// the counter never wraps.
module mem_port_sequencer_run_counter
    import mem_port_sequencer_pkg::*;
#(
    parameter int unsigned CYCLE_WIDTH = SEQ_CYCLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [CYCLE_WIDTH-1:0] load_val,
    input  logic                   en,
    output logic                   count_is_one
);

    logic [CYCLE_WIDTH-1:0] count_q;
    logic [CYCLE_WIDTH-1:0] count_d;
    logic                   is_one_q;
    logic                   is_one_d;

    // Next count and its "equals one" flag, registered together.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CYCLE_WIDTH'(1);
        end
        is_one_d = (count_d == CYCLE_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            is_one_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            is_one_q <= is_one_d;
        end
    end

    assign count_is_one = is_one_q;

endmodule

// File: rtl/mem_port_sequencer.sv
// Owner of the single memory port. In LOAD the host loader gets the port;
// on start the core is reset, triggered and given the port for run_cycles
// cycles (or until stop), then the port returns to the host and the core is
// frozen with its state intact.
//   clk, reset_n                     : clock, asynchronous active-low reset
//   host_req/we/addr/din             : host access request
//   host_gnt                         : host access performed this cycle (comb)
//   host_rvalid, host_rdata          : read return, one cycle after grant
//   start, stop, run_cycles          : run control (0 = unlimited)
//   core_addr/din/we                 : core side of the port
//   mem_addr/din/we (comb), mem_dout : memory side of the port
//   core_reset_n, core_en, trigger   : core control (registered)
//   busy, done                       : run status (registered)
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SEQ_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = SEQ_DATA_WIDTH,
    parameter int unsigned CYCLE_WIDTH = SEQ_CYCLE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0]  host_din,
    output logic                   host_gnt,
    output logic                   host_rvalid,
    output logic [DATA_WIDTH-1:0]  host_rdata,

    input  logic                   start,
    input  logic                   stop,
    input  logic [CYCLE_WIDTH-1:0] run_cycles,

    input  logic [ADDR_WIDTH-1:0]  core_addr,
    input  logic [DATA_WIDTH-1:0]  core_din,
    input  logic                   core_we,

    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_din,
    output logic                   mem_we,
    input  logic [DATA_WIDTH-1:0]  mem_dout,

    output logic                   core_reset_n,
    output logic                   core_en,
    output logic                   trigger,
    output logic                   busy,
    output logic                   done
);

    seq_state_e state_q;
    seq_state_e state_d;
    seq_ctl_t   ctl_q;
    seq_ctl_t   ctl_d;
    logic       host_rvalid_q;
    logic       host_rvalid_d;

    logic       ctr_load;
    logic       ctr_en;
    logic       count_is_one;
    logic       in_load;

    assign in_load = (state_q == SEQ_LOAD);

    // Run-length counter: loaded in ARM_RST so ARM_GO already sees the
    // programmed length and counts as the first core cycle of the run.
    mem_port_sequencer_run_counter #(
        .CYCLE_WIDTH (CYCLE_WIDTH)
    ) u_run_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (ctr_load),
        .load_val     (run_cycles),
        .en           (ctr_en),
        .count_is_one (count_is_one)
    );

    // Next state, counter control and next registered outputs.
    always_comb begin
        state_d       = state_q;
        ctr_load      = 1'b0;
        ctr_en        = 1'b0;
        case (state_q)
            SEQ_LOAD: begin
                if (start) begin
                    state_d = SEQ_ARM_RST;
                end
            end
            SEQ_ARM_RST: begin
                ctr_load = 1'b1;
                state_d  = SEQ_ARM_GO;
            end
            SEQ_ARM_GO: begin
                ctr_en  = 1'b1;
                state_d = count_is_one ? SEQ_DRAIN : SEQ_RUN;
            end
            SEQ_RUN: begin
                ctr_en = 1'b1;
                if (stop || count_is_one) begin
                    state_d = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                state_d = SEQ_LOAD;
            end
            default: begin
                state_d = SEQ_LOAD;
            end
        endcase
        // Outputs are decoded from the next state so they line up with it.
        ctl_d         = seq_ctl_decode(state_d, ctl_q.core_reset_n);
        host_rvalid_d = in_load && host_req && !host_we;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEQ_LOAD;
            ctl_q         <= SEQ_CTL_RESET;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctl_q         <= ctl_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Port mux: host in LOAD, core in ARM_GO/RUN, writes blocked otherwise.
    always_comb begin
        mem_addr = core_addr;
        mem_din  = core_din;
        mem_we   = 1'b0;
        case (state_q)
            SEQ_LOAD: begin
                mem_addr = '0;
                mem_din  = '0;
                if (host_req) begin
                    mem_addr = host_addr;
                    mem_din  = host_din;
                    mem_we   = host_we;
                end
            end
            SEQ_ARM_GO,
            SEQ_RUN: begin
                mem_we = core_we;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        // No write may slip through while reset is asserted.
        mem_we = mem_we && reset_n;
    end

    assign host_gnt     = reset_n && in_load && host_req;
    assign host_rvalid  = host_rvalid_q;
    assign host_rdata   = mem_dout;

    assign core_reset_n = ctl_q.core_reset_n;
    assign core_en      = ctl_q.core_en;
    assign trigger      = ctl_q.trigger;
    assign busy         = ctl_q.busy;
    assign done         = ctl_q.done;

endmodule

// File: tb/tb_mem_port_sequencer.sv
`timescale 1ns/1ps
// Bench for mem_port_sequencer: a memory model on the port, a schedule-based
// reference model compared every cycle, and directed scenarios with literal
// expectations.
module tb_mem_port_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned DEPTH = 1 << AW;

    localparam int PH_LOAD    = 0;
    localparam int PH_ARM_RST = 1;
    localparam int PH_ARM_GO  = 2;
    localparam int PH_RUN     = 3;
    localparam int PH_DRAIN   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          start, stop;
    logic [CW-1:0] run_cycles;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_din;
    logic          core_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          core_reset_n, core_en, trigger, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .CYCLE_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_din     (host_din),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .start        (start),
        .stop         (stop),
        .run_cycles   (run_cycles),
        .core_addr    (core_addr),
        .core_din     (core_din),
        .core_we      (core_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout),
        .core_reset_n (core_reset_n),
        .core_en      (core_en),
        .trigger      (trigger),
        .busy         (busy),
        .done         (done)
    );

    // Memory attached to the port: synchronous write, registered read.
    logic [DW-1:0] tb_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_din;
        mem_dout <= tb_mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a schedule relative to the cycle that
    // sampled start (ARM_RST at +1, ARM_GO at +2, DRAIN at end_cyc).
    int            cyc = 0;
    bit            in_run = 1'b0;
    int            t_start = 0;
    int            end_cyc = 0;
    bit            seen_go = 1'b0;
    bit            exp_rvalid = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    function automatic int phase_of(input int c);
        if (!in_run) return PH_LOAD;
        if (c - t_start == 1) return PH_ARM_RST;
        if (c - t_start == 2) return PH_ARM_GO;
        if (c == end_cyc) return PH_DRAIN;
        return PH_RUN;
    endfunction

    always @(posedge clk) begin : model_upd
        int p;
        if (reset_n !== 1'b1) begin
            in_run     = 1'b0;
            seen_go    = 1'b0;
            exp_rvalid = 1'b0;
            cyc        = 0;
        end else begin
            p = phase_of(cyc);
            exp_rvalid = (p == PH_LOAD) && host_req && !host_we;
            if (exp_rvalid) exp_rdata = ref_mem[host_addr];
            if (p == PH_LOAD && host_req && host_we) ref_mem[host_addr] = host_din;
            if ((p == PH_ARM_GO || p == PH_RUN) && core_we) ref_mem[core_addr] = core_din;
            if (p == PH_LOAD && start) begin
                in_run  = 1'b1;
                t_start = cyc;
                end_cyc = (run_cycles == '0) ? 32'h7fff_ffff : cyc + int'(run_cycles) + 2;
            end
            if (p == PH_RUN && stop && (cyc + 1 < end_cyc)) end_cyc = cyc + 1;
            if (p == PH_DRAIN) in_run = 1'b0;
            cyc++;
            p = phase_of(cyc);
            if (p == PH_ARM_RST) seen_go = 1'b0;
            if (p == PH_ARM_GO)  seen_go = 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        int p;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        if (reset_n === 1'b1) begin
            p = phase_of(cyc);
            check("m_busy",     32'(busy),         32'(p == PH_ARM_RST || p == PH_ARM_GO || p == PH_RUN));
            check("m_core_en",  32'(core_en),      32'(p == PH_ARM_GO || p == PH_RUN));
            check("m_trigger",  32'(trigger),      32'(p == PH_ARM_GO));
            check("m_done",     32'(done),         32'(p == PH_DRAIN));
            check("m_core_rst", 32'(core_reset_n), 32'(seen_go));
            check("m_gnt",      32'(host_gnt),     32'(p == PH_LOAD && host_req));
            check("m_rvalid",   32'(host_rvalid),  32'(exp_rvalid));
            if (exp_rvalid) check("m_rdata", 32'(host_rdata), 32'(exp_rdata));
            e_we = 1'b0;
            e_addr = core_addr;
            e_din = core_din;
            if (p == PH_LOAD) begin
                e_we = host_req && host_we;
                e_addr = host_addr;
                e_din = host_din;
            end else if (p == PH_ARM_GO || p == PH_RUN) begin
                e_we = core_we;
            end
            check("m_mem_we", 32'(mem_we), 32'(e_we));
            if ((p == PH_LOAD && host_req) || p == PH_ARM_GO || p == PH_RUN) begin
                check("m_mem_addr", 32'(mem_addr), 32'(e_addr));
                check("m_mem_din",  32'(mem_din),  32'(e_din));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int trig_cnt, trig_at, en_cnt, addr_bad, done_at, run_bad, done_extra, we_after, gnt_bad, mem_bad;

    initial begin
        reset_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
        start = 1'b0; stop = 1'b0; run_cycles = '0; core_addr = '0; core_din = '0; core_we = 1'b0;
        mem_dout = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tb_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        #2;
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_core_rst", 32'(core_reset_n), 32'd0);
        check("rst_core_en",  32'(core_en),      32'd0);
        check("rst_trigger",  32'(trigger),      32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_rvalid",   32'(host_rvalid),  32'd0);
        check("rst_gnt",      32'(host_gnt),     32'd0);
        step; step;
        reset_n = 1'b1;

        // Host write then readback.
        step;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h010; host_din = 8'hA5; #1;
        check("wr_gnt", 32'(host_gnt), 32'd1);
        check("wr_we",  32'(mem_we),   32'd1);
        step;
        host_we = 1'b0; #1;
        check("rd_gnt", 32'(host_gnt), 32'd1);
        check("rd_we",  32'(mem_we),   32'd0);
        step;
        host_req = 1'b0; #1;
        check("rd_rvalid", 32'(host_rvalid), 32'd1);
        check("rd_rdata",  32'(host_rdata),  32'hA5);
        step; #1;
        check("rd_rvalid_clr", 32'(host_rvalid), 32'd0);

        // Bounded run of 20 cycles.
        step;
        start = 1'b1; run_cycles = 16'd20;
        step;
        start = 1'b0; #1;
        check("b_arm_busy",     32'(busy),         32'd1);
        check("b_arm_core_rst", 32'(core_reset_n), 32'd0);
        check("b_arm_trigger",  32'(trigger),      32'd0);
        trig_cnt = 0; trig_at = -1; en_cnt = 0; addr_bad = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            step;
            core_addr = AW'(32'h200 + i); core_din = DW'(i); #1;
            if (trigger) begin
                trig_cnt++;
                if (trig_at < 0) trig_at = i;
            end
            if (core_en) begin
                en_cnt++;
                if (mem_addr !== core_addr) addr_bad++;
            end
            if (done) begin
                done_at = i;
                break;
            end
        end
        check("b_trig_cnt", 32'(trig_cnt), 32'd1);
        check("b_trig_at",  32'(trig_at),  32'd0);
        check("b_en_cnt",   32'(en_cnt),   32'd20);
        check("b_addr_bad", 32'(addr_bad), 32'd0);
        check("b_done_at",  32'(done_at),  32'd20);
        step;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010; #1;
        check("b_post_busy",     32'(busy),         32'd0);
        check("b_post_done",     32'(done),         32'd0);
        check("b_post_core_rst", 32'(core_reset_n), 32'd1);
        check("b_post_gnt",      32'(host_gnt),     32'd1);
        step;
        host_req = 1'b0;

        // Unlimited run ended by stop after 37 RUN cycles.
        core_addr = 10'h300; core_din = 8'h5A; core_we = 1'b1;
        start = 1'b1; run_cycles = 16'd0;
        step;
        start = 1'b0; #1;
        check("u_arm_rst_we", 32'(mem_we), 32'd0);
        step; #1;
        check("u_arm_go_trig", 32'(trigger), 32'd1);
        run_bad = 0;
        for (int i = 1; i <= 37; i++) begin
            step; #1;
            if (!(core_en && busy && mem_we)) run_bad++;
            if (i == 37) stop = 1'b1;
        end
        check("u_run_bad", 32'(run_bad), 32'd0);
        step;
        stop = 1'b0; #1;
        check("u_drain_done", 32'(done),    32'd1);
        check("u_drain_we",   32'(mem_we),  32'd0);
        check("u_drain_en",   32'(core_en), 32'd0);
        done_extra = 0; we_after = 0;
        for (int i = 0; i < 4; i++) begin
            step; #1;
            if (done) done_extra++;
            if (mem_we) we_after++;
        end
        check("u_done_extra", 32'(done_extra), 32'd0);
        check("u_we_after",   32'(we_after),   32'd0);
        core_we = 1'b0;

        // Host write held through a run of 8 cycles.
        core_addr = 10'h3F0;
        step;
        start = 1'b1; run_cycles = 16'd8;
        step;
        start = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 10'h001; host_din = 8'h3C;
        gnt_bad = 0; mem_bad = 0; done_at = -1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (host_gnt) gnt_bad++;
            if (tb_mem[1] !== 8'h00) mem_bad++;
            if (done) begin
                done_at = i;
                break;
            end
            step;
        end
        check("h_gnt_bad", 32'(gnt_bad), 32'd0);
        check("h_mem_bad", 32'(mem_bad), 32'd0);
        check("h_done_at", 32'(done_at), 32'd9);
        step; #1;
        check("h_gnt_load", 32'(host_gnt), 32'd1);
        check("h_we_load",  32'(mem_we),   32'd1);
        step;
        host_req = 1'b0; #1;
        check("h_mem_landed", 32'(tb_mem[1]), 32'h3C);

        // start and host write in the same LOAD cycle.
        step;
        start = 1'b1; run_cycles = 16'd3;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h020; host_din = 8'h77; #1;
        check("s_gnt", 32'(host_gnt), 32'd1);
        step;
        start = 1'b0; host_req = 1'b0; #1;
        check("s_busy",     32'(busy),         32'd1);
        check("s_core_rst", 32'(core_reset_n), 32'd0);
        check("s_mem",      32'(tb_mem[32]),   32'h77);
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            step; #1;
            if (done) begin
                done_at = i;
                break;
            end
        end
        check("s_done_at", 32'(done_at), 32'd3);

        // One-cycle run: ARM_GO straight to DRAIN.
        step;
        start = 1'b1; run_cycles = 16'd1;
        step;
        start = 1'b0;
        step; #1;
        check("one_trig", 32'(trigger), 32'd1);
        step; #1;
        check("one_done", 32'(done), 32'd1);
        step;

        // Reset in RUN cycle 5, then a complete run of 12.
        start = 1'b1; run_cycles = 16'd12;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 5; i++) step;
        #1;
        check("r_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0; #1;
        check("r_busy",     32'(busy),         32'd0);
        check("r_core_rst", 32'(core_reset_n), 32'd0);
        check("r_core_en",  32'(core_en),      32'd0);
        check("r_rvalid",   32'(host_rvalid),  32'd0);
        step; step;
        reset_n = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010; #1;
        check("r_load_gnt",  32'(host_gnt),     32'd1);
        check("r_keep_rst",  32'(core_reset_n), 32'd0);
        step;
        host_req = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        en_cnt = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            step; #1;
            if (core_en) en_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        check("r_en_cnt",  32'(en_cnt),  32'd12);
        check("r_done_at", 32'(done_at), 32'd12);
        step; step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
